// File: rtl/scan_pkg.sv
// Shared definitions for the LED-matrix scan receiver.
// Provides the matrix geometry, the capture state encoding and small helpers
// for one-hot row strobe decoding and frame bit addressing.
package scan_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    LOST    = 2'd2
  } cap_state_t;

  // True when exactly one bit of the strobe is set.
  function automatic logic is_onehot(input logic [ROWS-1:0] v);
    return (v != '0) && ((v & (v - ROWS'(1))) == '0);
  endfunction

  // Index of the set bit in a one-hot strobe (highest set bit otherwise).
  function automatic logic [2:0] onehot_idx(input logic [ROWS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Bit position of cell (r, c) inside a packed 64-bit frame.
  function automatic int cell_bit(input int r, input int c);
    return COLS * r + c;
  endfunction

endpackage

// File: rtl/matrix_scan_rx_if.sv
// Scan-line and frame bundle of the matrix scan receiver.
//   row_in, data_inv_in, clr_err : scan pads and error clear (master drives)
//   frame_out .. link_lost       : rebuilt frame and status (slave drives)
interface matrix_scan_rx_if;
  logic [7:0]  row_in;
  logic [7:0]  data_inv_in;
  logic        clr_err;
  logic [63:0] frame_out;
  logic        frame_valid;
  logic [15:0] frame_count;
  logic [2:0]  cur_row;
  logic        locked;
  logic        err_onehot;
  logic        err_seq;
  logic        link_lost;

  modport master (
    output row_in, data_inv_in, clr_err,
    input  frame_out, frame_valid, frame_count, cur_row,
    input  locked, err_onehot, err_seq, link_lost
  );

  modport slave (
    input  row_in, data_inv_in, clr_err,
    output frame_out, frame_valid, frame_count, cur_row,
    output locked, err_onehot, err_seq, link_lost
  );
endinterface

// File: rtl/scan_stabilizer.sv
// Synchronizes the scan pads and qualifies them with a stability counter.
//   clk, _rst     : clock, synchronous active-high reset
//   row_in        : raw one-hot row strobe
//   data_inv_in   : raw active-low row data
//   srow, sdat    : synchronized row/data captured at the acceptance edge
//   accept        : one-cycle strobe, srow/sdat valid alongside it
module scan_stabilizer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic [7:0] row_in,
  input  logic [7:0] data_inv_in,
  output logic [7:0] srow,
  output logic [7:0] sdat,
  output logic       accept
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [7:0]  row_sync [SYNC_STAGES];
  logic [7:0]  dat_sync [SYNC_STAGES];
  logic [7:0]  row_s;
  logic [7:0]  dat_s;
  logic [15:0] prev_q;
  logic [7:0]  stab_cnt;
  logic [7:0]  cnt_nxt;
  logic        changed;
  logic        fire;

  assign row_s = row_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Fire only on the edge the counter arrives at STABLE; a saturated counter
  // on unchanged lines must not re-accept. With STABLE_CYCLES=1 the arrival
  // edge is any change edge.
  always_comb begin
    changed = ({row_s, dat_s} != prev_q);
    if (changed)               cnt_nxt = 8'd1;
    else if (stab_cnt != STABLE) cnt_nxt = stab_cnt + 8'd1;
    else                       cnt_nxt = stab_cnt;
    fire = (cnt_nxt == STABLE) && (changed || (stab_cnt != STABLE));
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        row_sync[i] <= '0;
        dat_sync[i] <= '0;
      end
      prev_q   <= '0;
      stab_cnt <= '0;
      accept   <= 1'b0;
      srow     <= '0;
      sdat     <= '0;
    end else begin
      row_sync[0] <= row_in;
      dat_sync[0] <= data_inv_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        row_sync[i] <= row_sync[i-1];
        dat_sync[i] <= dat_sync[i-1];
      end
      prev_q   <= {row_s, dat_s};
      stab_cnt <= cnt_nxt;
      accept   <= fire;
      // Hold the accepted value so the FSM sees it even if the lines move on.
      if (fire) begin
        srow <= row_s;
        sdat <= dat_s;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_rx.sv
// Receiving end of the 8x8 LED-matrix scan: rebuilds 64-cell frames from the
// row strobe and active-low row data, publishes them with a one-cycle pulse
// and flags malformed scans.
//   clk, _rst : clock, synchronous active-high reset
//   bus       : scan pads, clr_err, frame_out/valid/count, cur_row, locked,
//               err_onehot, err_seq, link_lost
//
//   state   | meaning
//   HUNT    | waiting for row 0 to start a frame
//   CAPTURE | rows arriving in order, frame being assembled
//   LOST    | no accepted row for TIMEOUT clocks
module matrix_scan_rx
  import scan_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input logic              clk,
  input logic              _rst,
  matrix_scan_rx_if.slave  bus
);

  localparam logic [15:0] TO_MAX = 16'(TIMEOUT);

  logic        accept;
  logic [7:0]  srow;
  logic [7:0]  sdat;

  cap_state_t  state_q;
  logic [7:0]  seen_q;
  logic [63:0] buf_q;
  logic [63:0] frame_q;
  logic        valid_q;
  logic [15:0] count_q;
  logic [2:0]  cur_q;
  logic        err_onehot_q;
  logic        err_seq_q;
  logic [15:0] to_cnt;

  logic        row_acc;
  logic        bad_acc;
  logic        lost_hit;
  logic [2:0]  r;
  logic [2:0]  nxt_row;
  logic [63:0] assembled;

  scan_stabilizer #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk         (clk),
    ._rst        (_rst),
    .row_in      (bus.row_in),
    .data_inv_in (bus.data_inv_in),
    .srow        (srow),
    .sdat        (sdat),
    .accept      (accept)
  );

  always_comb begin
    row_acc   = accept && is_onehot(srow);
    bad_acc   = accept && (srow != '0) && !is_onehot(srow);
    r         = onehot_idx(srow);
    nxt_row   = cur_q + 3'd1;
    // Only the edge that brings the counter to TIMEOUT moves to LOST.
    lost_hit  = !row_acc && (to_cnt == TO_MAX - 16'd1);
    assembled = buf_q;
    assembled[COLS-1:0] = ~sdat;
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      state_q      <= HUNT;
      seen_q       <= '0;
      buf_q        <= '0;
      frame_q      <= '0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      cur_q        <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      valid_q <= 1'b0;

      if (row_acc)                to_cnt <= '0;
      else if (to_cnt != TO_MAX)  to_cnt <= to_cnt + 16'd1;

      // Clear first so a coincident error below keeps its flag set.
      if (bus.clr_err) begin
        err_onehot_q <= 1'b0;
        err_seq_q    <= 1'b0;
      end

      if (bad_acc) begin
        err_onehot_q <= 1'b1;
        seen_q       <= '0;
        state_q      <= HUNT;
      end

      if (row_acc) begin
        buf_q[cell_bit(int'(r), 0) +: COLS] <= ~sdat;
        cur_q <= r;
        unique case (state_q)
          CAPTURE: begin
            if (r == nxt_row && r != 3'd0) begin
              seen_q[r] <= 1'b1;
            end else if (r == nxt_row && seen_q == 8'hFF) begin
              frame_q <= assembled;
              valid_q <= 1'b1;
              count_q <= count_q + 16'd1;
              seen_q  <= 8'h01;
            end else begin
              // Out-of-order row; a row 0 restarts capture on the same edge.
              err_seq_q <= 1'b1;
              if (r == 3'd0) begin
                seen_q  <= 8'h01;
                state_q <= CAPTURE;
              end else begin
                seen_q  <= '0;
                state_q <= HUNT;
              end
            end
          end
          default: begin
            // HUNT and LOST both restart on row 0; LOST falls back to HUNT.
            if (r == 3'd0) begin
              seen_q  <= 8'h01;
              state_q <= CAPTURE;
            end else begin
              seen_q  <= '0;
              state_q <= HUNT;
            end
          end
        endcase
      end

      if (lost_hit) begin
        state_q <= LOST;
        seen_q  <= '0;
      end
    end
  end

  assign bus.frame_out   = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_count = count_q;
  assign bus.cur_row     = cur_q;
  assign bus.locked      = (state_q == CAPTURE);
  assign bus.err_onehot  = err_onehot_q;
  assign bus.err_seq     = err_seq_q;
  assign bus.link_lost   = (state_q == LOST);

endmodule

// File: tb/tb_matrix_scan_rx.sv
module tb_matrix_scan_rx;

  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int TOUT = 50;

  typedef struct packed {
    logic [63:0] frame;
    logic [15:0] count;
  } frame_t;

  logic clk = 1'b0;
  logic _rst = 1'b1;

  always #5 clk = ~clk;

  matrix_scan_rx_if bus ();

  matrix_scan_rx #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STAB),
    .TIMEOUT       (TOUT)
  ) dut (
    .clk  (clk),
    ._rst (_rst),
    .bus  (bus)
  );

  frame_t      exp_q[$];
  frame_t      obs_q[$];
  int          tests = 0;
  int          failed = 0;
  int          rd_ptr = 0;
  logic [15:0] exp_count = '0;

  // Record every published frame; the main sequence scores them.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) obs_q.push_back({bus.frame_out, bus.frame_count});
  end

  function automatic logic [7:0] pat(input logic [7:0] seed, input int r);
    return seed ^ 8'(r * 59);
  endfunction

  function automatic logic [63:0] build_frame(input logic [7:0] seed);
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < 8; r++) f[8*r +: 8] = ~pat(seed, r);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] rv, input logic [7:0] dv, input int hold);
    bus.row_in      = rv;
    bus.data_inv_in = dv;
    repeat (hold) @(negedge clk);
  endtask

  task automatic row(input int r, input logic [7:0] seed);
    drive(8'(1 << r), pat(seed, r), 10);
  endtask

  task automatic scan(input int first, input int last, input logic [7:0] seed);
    for (int r = first; r <= last; r++) row(r, seed);
  endtask

  task automatic expect_frame(input logic [63:0] f);
    exp_count++;
    exp_q.push_back({f, exp_count});
  endtask

  task automatic check_frames(input string tag);
    frame_t e;
    frame_t o;
    #1;
    tests++;
    assert (obs_q.size() === rd_ptr + exp_q.size()) else begin
      failed++;
      $error("FAIL %s_pulses observed=%0d expected=%0d", tag, obs_q.size() - rd_ptr, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_ptr < obs_q.size()) begin
        o = obs_q[rd_ptr];
        rd_ptr++;
        chk({tag, "_frame"}, o.frame, e.frame);
        chk({tag, "_count"}, 64'(o.count), 64'(e.count));
      end
    end
    rd_ptr = obs_q.size();
  endtask

  task automatic do_reset();
    bus.row_in      = 8'h00;
    bus.data_inv_in = 8'hFF;
    bus.clr_err     = 1'b0;
    _rst            = 1'b1;
    repeat (2) @(negedge clk);
    _rst            = 1'b0;
    exp_count       = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_frame_out"},   bus.frame_out, 64'h0);
    chk({tag, "_frame_valid"}, 64'(bus.frame_valid), 64'h0);
    chk({tag, "_frame_count"}, 64'(bus.frame_count), 64'h0);
    chk({tag, "_cur_row"},     64'(bus.cur_row), 64'h0);
    chk({tag, "_locked"},      64'(bus.locked), 64'h0);
    chk({tag, "_err_onehot"},  64'(bus.err_onehot), 64'h0);
    chk({tag, "_err_seq"},     64'(bus.err_seq), 64'h0);
    chk({tag, "_link_lost"},   64'(bus.link_lost), 64'h0);
  endtask

  initial begin
    logic [7:0] dv;
    bus.row_in      = 8'h00;
    bus.data_inv_in = 8'hFF;
    bus.clr_err     = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk_zero("reset");

    // Clean scan with diagonal pattern, plus publish latency
    for (int r = 0; r < 8; r++) begin
      dv = 8'h01 << r;
      drive(8'(1 << r), ~dv, 10);
    end
    bus.row_in      = 8'h01;
    bus.data_inv_in = 8'hFE;
    expect_frame(64'h8040201008040201);
    repeat (SYNC + STAB) @(negedge clk);
    chk("clean_valid_early", 64'(bus.frame_valid), 64'h0);
    @(negedge clk);
    chk("clean_valid", 64'(bus.frame_valid), 64'h1);
    chk("clean_frame_out", bus.frame_out, 64'h8040201008040201);
    @(negedge clk);
    chk("clean_valid_pulse", 64'(bus.frame_valid), 64'h0);
    repeat (2) @(negedge clk);
    chk("clean_locked", 64'(bus.locked), 64'h1);
    chk("clean_cur_row", 64'(bus.cur_row), 64'h0);
    check_frames("clean");

    // Glitch filter: short row 3 then short row 2 are never accepted
    do_reset();
    scan(0, 2, 8'h5A);
    drive(8'h08, 8'h00, 3);
    drive(8'h04, pat(8'h5A, 2), 3);
    chk("glitch_cur_row", 64'(bus.cur_row), 64'h2);
    chk("glitch_err_seq", 64'(bus.err_seq), 64'h0);
    chk("glitch_locked", 64'(bus.locked), 64'h1);
    scan(3, 7, 8'h5A);
    row(0, 8'h5A);
    expect_frame(build_frame(8'h5A));
    check_frames("glitch");
    chk("glitch_err_seq_end", 64'(bus.err_seq), 64'h0);

    // Skipped row
    do_reset();
    scan(0, 2, 8'hC3);
    row(4, 8'hC3);
    chk("skip_err_seq", 64'(bus.err_seq), 64'h1);
    chk("skip_locked", 64'(bus.locked), 64'h0);
    chk("skip_cur_row", 64'(bus.cur_row), 64'h4);
    check_frames("skip_none");
    scan(0, 7, 8'h3C);
    row(0, 8'h3C);
    expect_frame(build_frame(8'h3C));
    check_frames("skip_frame");
    chk("skip_err_sticky", 64'(bus.err_seq), 64'h1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("skip_clr", 64'(bus.err_seq), 64'h0);

    // Bad strobe with clr_err on the acceptance edge
    do_reset();
    scan(0, 1, 8'h77);
    chk("bad_pre_locked", 64'(bus.locked), 64'h1);
    bus.row_in      = 8'h18;
    bus.data_inv_in = 8'h00;
    repeat (SYNC + STAB) @(negedge clk);
    chk("bad_before", 64'(bus.err_onehot), 64'h0);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("bad_err_wins", 64'(bus.err_onehot), 64'h1);
    chk("bad_locked", 64'(bus.locked), 64'h0);
    chk("bad_link_lost", 64'(bus.link_lost), 64'h0);
    chk("bad_cur_row", 64'(bus.cur_row), 64'h1);
    repeat (3) @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("bad_clr", 64'(bus.err_onehot), 64'h0);
    check_frames("bad");

    // Timeout after row 5
    do_reset();
    scan(0, 4, 8'h96);
    drive(8'h20, pat(8'h96, 5), SYNC + STAB + 1 + TOUT - 1);
    chk("to_not_yet", 64'(bus.link_lost), 64'h0);
    @(negedge clk);
    chk("to_lost", 64'(bus.link_lost), 64'h1);
    chk("to_locked", 64'(bus.locked), 64'h0);
    repeat (3) @(negedge clk);
    scan(0, 7, 8'h96);
    row(0, 8'h96);
    expect_frame(build_frame(8'h96));
    chk("to_recover", 64'(bus.link_lost), 64'h0);
    check_frames("timeout");

    // Reset mid-frame
    do_reset();
    scan(0, 7, 8'h2B);
    row(0, 8'h2B);
    expect_frame(build_frame(8'h2B));
    check_frames("pre_reset");
    scan(1, 4, 8'h2B);
    _rst = 1'b1;
    @(negedge clk);
    _rst = 1'b0;
    exp_count = '0;
    chk_zero("midreset");
    scan(5, 7, 8'h2B);
    row(0, 8'h2B);
    check_frames("midreset_noframe");
    chk("midreset_locked", 64'(bus.locked), 64'h1);
    scan(1, 7, 8'h2B);
    row(0, 8'h2B);
    expect_frame(build_frame(8'h2B));
    check_frames("midreset_frame");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
